logic_unit_seq: RTL and testbench

//   Parametrised, multi-cycle bitwise logic unit; successor to the fixed 32-bit OR slice.

---
 rtl/logic_unit_seq.sv | 142 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: OR/AND/XOR/NOR on WIDTH-bit operands, SLICE bits per cycle.
// Produces a one-cycle result strobe plus any-bit-set / zero flags registered with the result.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy,
    output logic             flag_any,
    output logic             flag_zero,
    output logic [1:0]       dbg_state
);
    localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
    localparam int N          = WIDTH / SLICE_SAFE;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("logic_unit_seq: SLICE must be at least 1");
        end else if (WIDTH % SLICE_SAFE != 0) begin : g_bad_width
            $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    function automatic logic [SLICE_SAFE-1:0] op_fn(input logic [1:0] op,
                                                    input logic [SLICE_SAFE-1:0] x,
                                                    input logic [SLICE_SAFE-1:0] y);
        case (op)
            2'b00:   op_fn = x | y;
            2'b01:   op_fn = x & y;
            2'b10:   op_fn = x ^ y;
            default: op_fn = ~(x | y);
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      opa_q, opa_d, opb_q, opb_d;
    logic [1:0]            op_q, op_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic                  any_q, any_d;
    logic [SLICE_SAFE-1:0] slice_a, slice_b, slice_res;
    logic [WIDTH-1:0]      acc_merged;

    // Slice selected by idx_q, combined, and merged into the accumulator image.
    always_comb begin
        slice_a    = '0;
        slice_b    = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = opa_q[i*SLICE_SAFE +: SLICE_SAFE];
                slice_b = opb_q[i*SLICE_SAFE +: SLICE_SAFE];
            end
        end
        slice_res  = op_fn(op_q, slice_a, slice_b);
        acc_merged = acc_q;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                acc_merged[i*SLICE_SAFE +: SLICE_SAFE] = slice_res;
            end
        end
    end

    // Handshake: ctrl_start is taken on any edge where state is IDLE or DONE (not busy);
    // it is ignored during RUN. data_resultRDY is high for the single DONE cycle only.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        any_d    = any_q;
        case (state_q)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    opa_d   = data_operandA;
                    opb_d   = data_operandB;
                    op_d    = ctrl_op;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_merged;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    result_d = acc_merged;
                    any_d    = |acc_merged;
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            any_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            any_q    <= any_d;
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);
    assign flag_any       = any_q;
    assign flag_zero      = ~any_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: three configurations (32/8, 32/32, 16/4),
// directed vectors pushed into expected queues, monitors pop on data_resultRDY.
module tb_logic_unit_seq;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    logic        a_start, a_rdy, a_busy, a_any, a_zero;
    logic [1:0]  a_op, a_st;
    logic [31:0] a_a, a_b, a_res;
    logic        b_start, b_rdy, b_busy, b_any, b_zero;
    logic [1:0]  b_op, b_st;
    logic [31:0] b_a, b_b, b_res;
    logic        c_start, c_rdy, c_busy, c_any, c_zero;
    logic [1:0]  c_op, c_st;
    logic [15:0] c_a, c_b, c_res;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut_a (
        .clock(clock), .reset(reset), .ctrl_start(a_start), .ctrl_op(a_op),
        .data_operandA(a_a), .data_operandB(a_b), .data_result(a_res),
        .data_resultRDY(a_rdy), .busy(a_busy), .flag_any(a_any), .flag_zero(a_zero),
        .dbg_state(a_st));
    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut_b (
        .clock(clock), .reset(reset), .ctrl_start(b_start), .ctrl_op(b_op),
        .data_operandA(b_a), .data_operandB(b_b), .data_result(b_res),
        .data_resultRDY(b_rdy), .busy(b_busy), .flag_any(b_any), .flag_zero(b_zero),
        .dbg_state(b_st));
    logic_unit_seq #(.WIDTH(16), .SLICE(4)) dut_c (
        .clock(clock), .reset(reset), .ctrl_start(c_start), .ctrl_op(c_op),
        .data_operandA(c_a), .data_operandB(c_b), .data_result(c_res),
        .data_resultRDY(c_rdy), .busy(c_busy), .flag_any(c_any), .flag_zero(c_zero),
        .dbg_state(c_st));

    // Expected entries are {flag_any, flag_zero, result}; cycle queues hold the RDY edge number.
    logic [33:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];
    int          cyc_q_a[$], cyc_q_b[$], cyc_q_c[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
        case (op)
            2'b00:   model = x | y;
            2'b01:   model = x & y;
            2'b10:   model = x ^ y;
            default: model = ~(x | y);
        endcase
    endfunction

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input int which, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input bit push);
        logic [31:0] r;
        logic [33:0] e;
        r = model(op, x, y);
        case (which)
            0: begin a_start = 1'b1; a_op = op; a_a = x; a_b = y; end
            1: begin b_start = 1'b1; b_op = op; b_a = x; b_b = y; end
            default: begin
                c_start = 1'b1; c_op = op; c_a = x[15:0]; c_b = y[15:0];
                r = r & 32'h0000_FFFF;
            end
        endcase
        e = {|r, ~|r, r};
        if (push) begin
            case (which)
                0: begin exp_q_a.push_back(e); cyc_q_a.push_back(edge_cnt + 1 + 4); end
                1: begin exp_q_b.push_back(e); cyc_q_b.push_back(edge_cnt + 1 + 1); end
                default: begin exp_q_c.push_back(e); cyc_q_c.push_back(edge_cnt + 1 + 4); end
            endcase
        end
        @(negedge clock);
        case (which)
            0: a_start = 1'b0;
            1: b_start = 1'b0;
            default: c_start = 1'b0;
        endcase
    endtask

    task automatic wait_rdy(input int which);
        logic r;
        int   t;
        t = 0;
        r = (which == 0) ? a_rdy : (which == 1) ? b_rdy : c_rdy;
        while (!r && t < 40) begin
            @(negedge clock);
            t++;
            r = (which == 0) ? a_rdy : (which == 1) ? b_rdy : c_rdy;
        end
        check($sformatf("rdy_within_budget_%0d", which), r, 1);
    endtask

    always @(negedge clock) begin
        if (a_rdy) begin
            if (exp_q_a.size() == 0) check("a_unexpected_rdy", a_rdy, 0);
            else begin
                logic [33:0] e;
                int c;
                e = exp_q_a.pop_front();
                c = cyc_q_a.pop_front();
                check("a_result", a_res, e[31:0]);
                check("a_flags", {a_any, a_zero}, e[33:32]);
                check("a_latency", edge_cnt, c);
            end
        end
    end

    always @(negedge clock) begin
        if (b_rdy) begin
            if (exp_q_b.size() == 0) check("b_unexpected_rdy", b_rdy, 0);
            else begin
                logic [33:0] e;
                int c;
                e = exp_q_b.pop_front();
                c = cyc_q_b.pop_front();
                check("b_result", b_res, e[31:0]);
                check("b_flags", {b_any, b_zero}, e[33:32]);
                check("b_latency", edge_cnt, c);
            end
        end
    end

    always @(negedge clock) begin
        if (c_rdy) begin
            if (exp_q_c.size() == 0) check("c_unexpected_rdy", c_rdy, 0);
            else begin
                logic [33:0] e;
                int c;
                e = exp_q_c.pop_front();
                c = cyc_q_c.pop_front();
                check("c_result", c_res, e[15:0]);
                check("c_flags", {c_any, c_zero}, e[33:32]);
                check("c_latency", edge_cnt, c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first;
        reset   = 1'b1;
        a_start = 1'b0; a_op = 2'b00; a_a = '0; a_b = '0;
        b_start = 1'b0; b_op = 2'b00; b_a = '0; b_b = '0;
        c_start = 1'b0; c_op = 2'b00; c_a = '0; c_b = '0;
        repeat (2) @(negedge clock);
        check("reset_result", a_res, 32'h0);
        check("reset_flags", {a_any, a_zero}, 2'b01);
        check("reset_busy_rdy", {a_busy, a_rdy}, 2'b00);
        check("reset_state", a_st, 2'd0);
        reset = 1'b0;
        @(negedge clock);

        // OR with busy/RDY timing: busy after accept edge and three more, then DONE.
        issue(0, 2'b00, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("or_busy_%0d", i), {a_busy, a_rdy}, 2'b10);
            @(negedge clock);
        end
        check("or_done_cycle", {a_busy, a_rdy}, 2'b01);
        @(negedge clock);
        check("or_rdy_single", a_rdy, 1'b0);

        issue(0, 2'b01, 32'hFFFF_0000, 32'h00FF_FF00, 1'b1);
        wait_rdy(0);
        @(negedge clock);
        issue(0, 2'b10, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1);
        wait_rdy(0);
        check("xor_zero_flag", a_zero, 1'b1);
        @(negedge clock);

        // NOR with input churn and start pulses during RUN; none of it may matter.
        issue(0, 2'b11, 32'h0, 32'h0, 1'b1);
        a_start = 1'b1; a_op = 2'b01; a_a = 32'h1234_5678; a_b = 32'h9ABC_DEF0;
        @(negedge clock);
        a_start = 1'b0;
        check("hold_during_run", a_res, 32'h0);
        @(negedge clock);
        a_start = 1'b1; a_a = 32'hDEAD_BEEF;
        @(negedge clock);
        a_start = 1'b0;
        wait_rdy(0);
        repeat (3) @(negedge clock);

        // Back-to-back: start held through RUN, new operands presented in DONE.
        issue(0, 2'b00, 32'h1234_0000, 32'h0000_5678, 1'b1);
        a_start = 1'b1; a_op = 2'b11; a_a = 32'hFFFF_FFFF; a_b = 32'h0;
        wait_rdy(0);
        t_first = edge_cnt;
        issue(0, 2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        wait_rdy(0);
        check("b2b_spacing", edge_cnt - t_first, 5);
        @(negedge clock);

        // Reset in the middle of a RUN: abandoned, no RDY, outputs cleared at once.
        issue(0, 2'b10, 32'hFFFF_0000, 32'h0, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_result", a_res, 32'h0);
        check("midrun_reset_flags", {a_any, a_zero}, 2'b01);
        check("midrun_reset_busy_rdy", {a_busy, a_rdy}, 2'b00);
        check("midrun_reset_state", a_st, 2'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        issue(0, 2'b00, 32'h0000_00F0, 32'h0000_0F00, 1'b1);
        wait_rdy(0);
        @(negedge clock);

        // Single-cycle configuration.
        issue(1, 2'b00, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b1);
        check("n1_busy", b_busy, 1'b1);
        wait_rdy(1);
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            issue(1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
            wait_rdy(1);
            @(negedge clock);
        end

        // Narrow configuration, directed NOR then random ops.
        issue(2, 2'b11, 32'h0000_0F0F, 32'h0000_00F0, 1'b1);
        wait_rdy(2);
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            issue(2, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
            wait_rdy(2);
            @(negedge clock);
        end

        repeat (4) @(negedge clock);
        check("a_queue_drained", exp_q_a.size(), 0);
        check("b_queue_drained", exp_q_b.size(), 0);
        check("c_queue_drained", exp_q_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
